// File: rtl/risc_ctrl.sv
// Instruction-sequencing controller for the 8-bit RISC core: fixed 8-cycle
// frame (two byte fetches, decode, execute) driving the datapath strobes.
module risc_ctrl #(
    parameter int unsigned OP_W = 3,
    parameter int unsigned ST_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output logic            sel,
    output logic            rd,
    output logic            wr,
    output logic            load_ir,
    output logic            ir_hi,
    output logic            inc_pc,
    output logic            load_pc,
    output logic            load_acc,
    output logic            datactl_ena,
    output logic            halt,
    output logic [ST_W-1:0] state
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        S0   = 4'd1,
        S1   = 4'd2,
        S2   = 4'd3,
        S3   = 4'd4,
        S4   = 4'd5,
        S5   = 4'd6,
        S6   = 4'd7,
        S7   = 4'd8,
        HALT = 4'd9
    } state_t;

    localparam logic [OP_W-1:0] OP_HLT = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SKZ = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LDA = OP_W'(5);
    localparam logic [OP_W-1:0] OP_STO = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(7);

    state_t state_q, state_d;
    logic   zero_q;
    logic   ena_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            zero_q  <= 1'b0;
            ena_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ena_q   <= ena;
            // Flag is frozen at decode so late ALU changes cannot alter a skip.
            if (state_q == S2) begin
                zero_q <= zero;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ena ? S0 : IDLE;
            S0:      state_d = S1;
            S1:      state_d = S2;
            S2:      state_d = S3;
            S3:      state_d = (opcode == OP_HLT) ? HALT : S4;
            S4:      state_d = S5;
            S5:      state_d = S6;
            S6:      state_d = S7;
            S7:      state_d = ena ? S0 : IDLE;
            // Restart needs a fresh rising ena, so a held ena cannot bypass HLT.
            HALT:    state_d = (ena && !ena_q) ? S0 : HALT;
            default: state_d = IDLE;
        endcase
    end

    logic is_alu;
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

    always_comb begin
        sel         = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        load_ir     = 1'b0;
        ir_hi       = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        load_acc    = 1'b0;
        datactl_ena = 1'b0;
        halt        = 1'b0;
        case (state_q)
            S0: begin
                rd      = 1'b1;
                load_ir = 1'b1;
                ir_hi   = 1'b1;
                inc_pc  = 1'b1;
            end
            S1: begin
                rd      = 1'b1;
                load_ir = 1'b1;
                inc_pc  = 1'b1;
            end
            S3, S4, S5: begin
                if (is_alu) begin
                    sel      = 1'b1;
                    rd       = 1'b1;
                    load_acc = (state_q == S4);
                end else if (opcode == OP_STO) begin
                    sel         = 1'b1;
                    datactl_ena = 1'b1;
                    wr          = (state_q == S4);
                end else if (opcode == OP_SKZ) begin
                    inc_pc = zero_q && (state_q != S5);
                end else if (opcode == OP_JMP) begin
                    load_pc = (state_q == S4);
                end else if (opcode == OP_HLT) begin
                    halt = (state_q == S3);
                end
            end
            HALT:    halt = 1'b1;
            default: ;
        endcase
    end

    assign state = ST_W'(state_q);

endmodule

// File: tb/tb_risc_ctrl.sv
// Directed-vector bench for risc_ctrl: per-cycle table plus frame-level sequences.
module tb_risc_ctrl;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_S0   = 4'd1;
    localparam logic [3:0] ST_S1   = 4'd2;
    localparam logic [3:0] ST_S2   = 4'd3;
    localparam logic [3:0] ST_S3   = 4'd4;
    localparam logic [3:0] ST_S4   = 4'd5;
    localparam logic [3:0] ST_S5   = 4'd6;
    localparam logic [3:0] ST_S6   = 4'd7;
    localparam logic [3:0] ST_S7   = 4'd8;
    localparam logic [3:0] ST_HALT = 4'd9;

    // {sel, rd, wr, load_ir, ir_hi, inc_pc, load_pc, load_acc, datactl_ena, halt}
    localparam logic [9:0] O_NONE = 10'b0000000000;
    localparam logic [9:0] O_F0   = 10'b0101110000;
    localparam logic [9:0] O_F1   = 10'b0101010000;
    localparam logic [9:0] O_RD   = 10'b1100000000;
    localparam logic [9:0] O_RDL  = 10'b1100000100;
    localparam logic [9:0] O_ST   = 10'b1000000010;
    localparam logic [9:0] O_STW  = 10'b1010000010;
    localparam logic [9:0] O_INC  = 10'b0000010000;
    localparam logic [9:0] O_JMP  = 10'b0000001000;
    localparam logic [9:0] O_HLT  = 10'b0000000001;

    logic       clk = 1'b0;
    logic       rst_n, ena, zero;
    logic [2:0] opcode;
    logic       sel, rd, wr, load_ir, ir_hi, inc_pc, load_pc, load_acc, datactl_ena, halt;
    logic [3:0] state;
    logic [9:0] act;

    always #5 clk = ~clk;

    risc_ctrl #(.OP_W(3), .ST_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
        .sel(sel), .rd(rd), .wr(wr), .load_ir(load_ir), .ir_hi(ir_hi),
        .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc),
        .datactl_ena(datactl_ena), .halt(halt), .state(state)
    );

    assign act = {sel, rd, wr, load_ir, ir_hi, inc_pc, load_pc, load_acc, datactl_ena, halt};

    typedef struct {
        logic       rst_n;
        logic       ena;
        logic [2:0] op;
        logic       zero;
        logic [3:0] st;
        logic [9:0] out;
    } vec_t;

    vec_t vec[$];
    int unsigned total  = 0;
    int unsigned passed = 0;

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, got, exp);
    endtask

    task automatic row(input logic r, input logic e, input logic [2:0] o, input logic z,
                       input logic [3:0] s, input logic [9:0] x);
        vec_t v;
        v.rst_n = r; v.ena = e; v.op = o; v.zero = z; v.st = s; v.out = x;
        vec.push_back(v);
    endtask

    // Full 8-cycle frame with ena=1; zero is z2 in S2 and zl afterwards.
    task automatic frame(input logic [2:0] o, input logic z2, input logic zl,
                         input logic [9:0] x3, input logic [9:0] x4, input logic [9:0] x5);
        row(1, 1, o, 0,  ST_S0, O_F0);
        row(1, 1, o, 0,  ST_S1, O_F1);
        row(1, 1, o, z2, ST_S2, O_NONE);
        row(1, 1, o, zl, ST_S3, x3);
        row(1, 1, o, zl, ST_S4, x4);
        row(1, 1, o, zl, ST_S5, x5);
        row(1, 1, o, zl, ST_S6, O_NONE);
        row(1, 1, o, zl, ST_S7, O_NONE);
    endtask

    // Run one frame from IDLE/S7 and count strobes over the 8 cycles.
    task automatic run_frame(input string name, input logic [2:0] o, input logic z,
                             input int exp_inc, input int exp_acc);
        int n_inc = 0, n_acc = 0, n_conf = 0, k = 0;
        @(negedge clk);
        opcode = o; zero = z; ena = 1'b1; rst_n = 1'b1;
        #1;
        while (state !== ST_S0 && k < 20) begin
            @(negedge clk); #1; k++;
        end
        check({name, " reach S0"}, {6'd0, state}, {6'd0, ST_S0});
        for (int c = 0; c < 8; c++) begin
            n_inc += int'(inc_pc);
            n_acc += int'(load_acc);
            n_conf += int'((wr || load_pc) && rd);
            @(negedge clk); #1;
        end
        check({name, " inc_pc count"}, 10'(n_inc), 10'(exp_inc));
        check({name, " load_acc count"}, 10'(n_acc), 10'(exp_acc));
        check({name, " rd conflict"}, 10'(n_conf), 10'd0);
        check({name, " S0 after 8"}, {6'd0, state}, {6'd0, ST_S0});
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; opcode = 3'b000; zero = 1'b0;

        row(0, 1, 3'b101, 0, ST_IDLE, O_NONE);
        row(0, 1, 3'b101, 0, ST_IDLE, O_NONE);
        row(1, 1, 3'b101, 0, ST_IDLE, O_NONE);
        frame(3'b101, 0, 0, O_RD, O_RDL, O_RD);      // LDA
        frame(3'b110, 0, 0, O_ST, O_STW, O_ST);      // STO
        frame(3'b001, 1, 0, O_INC, O_INC, O_NONE);   // SKZ taken
        frame(3'b001, 0, 1, O_NONE, O_NONE, O_NONE); // SKZ not taken
        frame(3'b111, 0, 0, O_NONE, O_JMP, O_NONE);  // JMP
        row(1, 1, 3'b000, 0, ST_S0, O_F0);           // HLT
        row(1, 1, 3'b000, 0, ST_S1, O_F1);
        row(1, 1, 3'b000, 0, ST_S2, O_NONE);
        row(1, 1, 3'b000, 0, ST_S3, O_HLT);
        for (int i = 0; i < 5; i++) row(1, 1, 3'b000, 0, ST_HALT, O_HLT);
        row(1, 0, 3'b000, 0, ST_HALT, O_HLT);
        row(1, 1, 3'b000, 0, ST_HALT, O_HLT);
        row(1, 1, 3'b110, 0, ST_S0, O_F0);           // STO reset in S4
        row(1, 1, 3'b110, 0, ST_S1, O_F1);
        row(1, 1, 3'b110, 0, ST_S2, O_NONE);
        row(1, 1, 3'b110, 0, ST_S3, O_ST);
        row(0, 1, 3'b110, 0, ST_S4, O_STW);
        row(1, 1, 3'b110, 0, ST_IDLE, O_NONE);
        row(1, 1, 3'b010, 0, ST_S0, O_F0);           // ADD, ena dropped in S2
        row(1, 1, 3'b010, 0, ST_S1, O_F1);
        row(1, 0, 3'b010, 0, ST_S2, O_NONE);
        row(1, 0, 3'b010, 0, ST_S3, O_RD);
        row(1, 0, 3'b010, 0, ST_S4, O_RDL);
        row(1, 0, 3'b010, 0, ST_S5, O_RD);
        row(1, 0, 3'b010, 0, ST_S6, O_NONE);
        row(1, 0, 3'b010, 0, ST_S7, O_NONE);
        row(1, 0, 3'b010, 0, ST_IDLE, O_NONE);
        row(1, 0, 3'b010, 0, ST_IDLE, O_NONE);

        foreach (vec[i]) begin
            @(negedge clk);
            rst_n = vec[i].rst_n; ena = vec[i].ena; opcode = vec[i].op; zero = vec[i].zero;
            #1;
            check($sformatf("row %0d state", i), {6'd0, state}, {6'd0, vec[i].st});
            check($sformatf("row %0d outputs", i), act, vec[i].out);
        end

        run_frame("AND", 3'b011, 1'b0, 2, 1);
        run_frame("XOR", 3'b100, 1'b1, 2, 1);
        run_frame("SKZ taken", 3'b001, 1'b1, 4, 0);
        run_frame("STO", 3'b110, 1'b0, 2, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
